// File: rtl/car_link_ctrl.sv
// car_link_ctrl: power sequencing, command framing toward a UART transmitter,
// and detector-status reception with link-loss timeout.
module car_link_ctrl #(
   parameter int unsigned CMD_W       = 6,
   parameter int unsigned DET_W       = 4,
   parameter int unsigned HOLD_CYCLES = 100000000,
   parameter int unsigned TX_PERIOD   = 5000000,
   parameter int unsigned RX_TIMEOUT  = 50000000
) (
   input  logic             sys_clk,
   input  logic             rst,
   input  logic             power_on_signal,
   input  logic             power_off_signal,
   input  logic [CMD_W-1:0] cmd_in,
   output logic             poweron,
   output logic             poweroff,
   output logic [7:0]       tx_data,
   output logic             tx_valid,
   input  logic             tx_ready,
   input  logic [7:0]       rx_data,
   input  logic             rx_valid,
   output logic [DET_W-1:0] det_out,
   output logic             link_ok
);

   localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam int unsigned PER_W  = $clog2(TX_PERIOD);
   localparam int unsigned RXT_W  = $clog2(RX_TIMEOUT);

   typedef enum logic [1:0] {StOff, StArming, StOn} pwr_state_e;

   pwr_state_e        state_q, state_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [CMD_W-1:0]  cmd_q;
   logic [CMD_W-1:0]  last_sent_q;
   logic [7:0]        tx_data_q;
   logic              tx_valid_q;
   logic              off_pend_q;
   logic [PER_W-1:0]  per_cnt_q;
   logic [RXT_W-1:0]  rx_cnt_q;
   logic [DET_W-1:0]  det_q;
   logic              link_q;

   logic [7:0] frame;
   logic       is_on;
   logic       off_evt;
   logic       per_hit;
   logic       accept;
   logic       load_off;
   logic       load_cmd;
   logic       rx_timeout;
   logic       unused_rx;

   assign unused_rx = ^rx_data;

   // Power FSM state and hold counter registers.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state_q    <= StOff;
         hold_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
      end
   end

   // Power FSM next state; power_off_signal dominates in every state.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StOff: begin
            if (!power_off_signal && power_on_signal) state_d = StArming;
         end
         StArming: begin
            if (power_off_signal || !power_on_signal) begin
               state_d = StOff;
            end else if (hold_cnt_q == HOLD_W'(HOLD_CYCLES - 1)) begin
               state_d = StOn;
            end
         end
         StOn: begin
            if (power_off_signal) state_d = StOff;
         end
         default: state_d = StOff;
      endcase
      // Counter only runs while arming continues; cleared on entry and elsewhere.
      hold_cnt_d = (state_q == StArming && state_d == StArming) ?
                   hold_cnt_q + HOLD_W'(1) : '0;
   end

   // Command sampling, zeroed whenever the car is not powered.
   always_ff @(posedge sys_clk) begin
      if (rst || state_q != StOn) cmd_q <= '0;
      else                        cmd_q <= cmd_in;
   end

   // Frame assembly and send-trigger decode.
   always_comb begin
      frame             = 8'h80;
      frame[CMD_W-1:0]  = cmd_q;
      is_on             = (state_q == StOn);
      off_evt           = is_on && power_off_signal;
      per_hit           = (per_cnt_q == PER_W'(TX_PERIOD - 1));
      accept            = tx_valid_q && tx_ready;
      // A power-off frame that collides with a pending frame is remembered in off_pend_q.
      load_off          = !tx_valid_q && (off_evt || off_pend_q);
      load_cmd          = !tx_valid_q && !load_off && is_on &&
                          ((cmd_q != last_sent_q) || per_hit);
   end

   // Transmit handshake: the frame is frozen while pending; acceptance idles one cycle.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         tx_valid_q  <= 1'b0;
         tx_data_q   <= 8'h80;
         last_sent_q <= '0;
         off_pend_q  <= 1'b0;
      end else begin
         if (accept) begin
            tx_valid_q  <= 1'b0;
            last_sent_q <= tx_data_q[CMD_W-1:0];
         end else if (load_off) begin
            tx_valid_q <= 1'b1;
            tx_data_q  <= 8'h80;
         end else if (load_cmd) begin
            tx_valid_q <= 1'b1;
            tx_data_q  <= frame;
         end
         if (load_off)     off_pend_q <= 1'b0;
         else if (off_evt) off_pend_q <= 1'b1;
      end
   end

   // Keep-alive period counter; saturates until the pending frame is accepted.
   always_ff @(posedge sys_clk) begin
      if (rst || !is_on || accept) per_cnt_q <= '0;
      else if (!per_hit)           per_cnt_q <= per_cnt_q + PER_W'(1);
   end

   assign rx_timeout = (rx_cnt_q == RXT_W'(RX_TIMEOUT - 1));

   // Receive path: a fresh byte always beats the timeout.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         rx_cnt_q <= '0;
         det_q    <= '0;
         link_q   <= 1'b0;
      end else if (rx_valid) begin
         rx_cnt_q <= '0;
         det_q    <= rx_data[DET_W-1:0];
         link_q   <= 1'b1;
      end else if (rx_timeout) begin
         det_q    <= '0;
         link_q   <= 1'b0;
      end else begin
         rx_cnt_q <= rx_cnt_q + RXT_W'(1);
      end
   end

   assign poweron  = (state_q == StOn);
   assign poweroff = (state_q != StOn);
   assign tx_data  = tx_data_q;
   assign tx_valid = tx_valid_q;
   assign det_out  = det_q;
   assign link_ok  = link_q;

endmodule

// File: tb/tb_car_link_ctrl.sv
// Directed testbench for car_link_ctrl with small timing parameters.
module tb_car_link_ctrl;

   logic       sys_clk = 1'b0;
   logic       rst = 1'b1;
   logic       power_on_signal = 1'b0;
   logic       power_off_signal = 1'b0;
   logic [5:0] cmd_in = '0;
   logic       poweron, poweroff;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready = 1'b0;
   logic [7:0] rx_data = '0;
   logic       rx_valid = 1'b0;
   logic [3:0] det_out;
   logic       link_ok;

   int         checks = 0;
   int         failures = 0;
   int         acc_cnt = 0;
   logic [7:0] last_acc = '0;

   car_link_ctrl #(
      .CMD_W      (6),
      .DET_W      (4),
      .HOLD_CYCLES(4),
      .TX_PERIOD  (16),
      .RX_TIMEOUT (8)
   ) dut (
      .sys_clk         (sys_clk),
      .rst             (rst),
      .power_on_signal (power_on_signal),
      .power_off_signal(power_off_signal),
      .cmd_in          (cmd_in),
      .poweron         (poweron),
      .poweroff        (poweroff),
      .tx_data         (tx_data),
      .tx_valid        (tx_valid),
      .tx_ready        (tx_ready),
      .rx_data         (rx_data),
      .rx_valid        (rx_valid),
      .det_out         (det_out),
      .link_ok         (link_ok)
   );

   always #5 sys_clk = ~sys_clk;

   // Record every completed transmit handshake.
   always @(posedge sys_clk) begin
      if (!rst && tx_valid && tx_ready) begin
         acc_cnt  <= acc_cnt + 1;
         last_acc <= tx_data;
      end
   end

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   initial begin
      int n;
      logic quiet;

      // Reset state
      repeat (2) tick();
      rst = 1'b0;
      check_eq("rst_poweron", poweron, 0);
      check_eq("rst_poweroff", poweroff, 1);
      check_eq("rst_tx_valid", tx_valid, 0);
      check_eq("rst_tx_data", tx_data, 8'h80);
      check_eq("rst_det", det_out, 0);
      check_eq("rst_link", link_ok, 0);

      // Short power-on press is rejected
      power_on_signal = 1'b1;
      repeat (3) tick();
      power_on_signal = 1'b0;
      tick();
      check_eq("short_poweron", poweron, 0);
      check_eq("short_poweroff", poweroff, 1);

      // Full hold: ARMING counts 0..3 then ON
      power_on_signal = 1'b1;
      repeat (4) tick();
      check_eq("arming_poweron", poweron, 0);
      tick();
      check_eq("on_poweron", poweron, 1);
      check_eq("on_poweroff", poweroff, 0);

      // First command frame
      power_on_signal = 1'b0;
      tx_ready = 1'b1;
      cmd_in = 6'b000001;
      tick();
      check_eq("cmd_latency", tx_valid, 0);
      tick();
      check_eq("cmd_valid", tx_valid, 1);
      check_eq("cmd_data", tx_data, 8'h81);
      tick();
      check_eq("cmd_drop", tx_valid, 0);
      check_eq("cmd_one_frame", acc_cnt, 1);

      // Keep-alive 16 cycles after acceptance
      quiet = 1'b1;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (tx_valid) quiet = 1'b0;
      end
      check_eq("ka_quiet", quiet, 1);
      check_eq("ka_no_extra", acc_cnt, 1);
      tick();
      check_eq("ka_valid", tx_valid, 1);
      check_eq("ka_data", tx_data, 8'h81);
      tick();
      check_eq("ka_accepted", acc_cnt, 2);

      // Backpressure holds the pending frame
      tx_ready = 1'b0;
      n = 0;
      while (!tx_valid && n < 40) begin
         tick();
         n++;
      end
      check_eq("bp_pending", tx_valid, 1);
      cmd_in = 6'b000100;
      repeat (3) tick();
      check_eq("bp_hold_valid", tx_valid, 1);
      check_eq("bp_hold_data", tx_data, 8'h81);
      tx_ready = 1'b1;
      tick();
      check_eq("bp_drop", tx_valid, 0);
      check_eq("bp_acc_data", last_acc, 8'h81);
      tick();
      check_eq("bp_next_valid", tx_valid, 1);
      check_eq("bp_next_data", tx_data, 8'h84);
      tick();
      check_eq("bp_next_acc", acc_cnt, 4);
      check_eq("bp_next_acc_data", last_acc, 8'h84);

      // Power-off sends one zero-command frame
      power_off_signal = 1'b1;
      tick();
      power_off_signal = 1'b0;
      check_eq("off_poweroff", poweroff, 1);
      check_eq("off_poweron", poweron, 0);
      check_eq("off_valid", tx_valid, 1);
      check_eq("off_data", tx_data, 8'h80);
      tick();
      check_eq("off_acc", acc_cnt, 5);
      check_eq("off_acc_data", last_acc, 8'h80);
      repeat (40) tick();
      check_eq("off_no_ka", acc_cnt, 5);
      check_eq("off_idle", tx_valid, 0);

      // Receive and timeout
      rx_valid = 1'b1;
      rx_data = 8'h05;
      tick();
      rx_valid = 1'b0;
      check_eq("rx_det", det_out, 4'b0101);
      check_eq("rx_link", link_ok, 1);
      repeat (7) tick();
      check_eq("rx_pre_to_link", link_ok, 1);
      check_eq("rx_pre_to_det", det_out, 4'b0101);
      tick();
      check_eq("rx_to_link", link_ok, 0);
      check_eq("rx_to_det", det_out, 0);

      // rx_valid coinciding with the timeout wins
      rx_valid = 1'b1;
      rx_data = 8'h3A;
      tick();
      rx_valid = 1'b0;
      check_eq("rx_trunc_det", det_out, 4'hA);
      repeat (7) tick();
      rx_valid = 1'b1;
      rx_data = 8'h0C;
      tick();
      rx_valid = 1'b0;
      check_eq("rx_win_det", det_out, 4'hC);
      check_eq("rx_win_link", link_ok, 1);

      // Reset during a pending frame
      power_on_signal = 1'b1;
      tx_ready = 1'b0;
      cmd_in = 6'b000010;
      repeat (5) tick();
      check_eq("re_on", poweron, 1);
      power_on_signal = 1'b0;
      repeat (2) tick();
      check_eq("re_pend_valid", tx_valid, 1);
      check_eq("re_pend_data", tx_data, 8'h82);
      rx_valid = 1'b1;
      rx_data = 8'h03;
      tick();
      rx_valid = 1'b0;
      check_eq("re_link", link_ok, 1);
      rst = 1'b1;
      tick();
      check_eq("re_tx_valid", tx_valid, 0);
      check_eq("re_link_drop", link_ok, 0);
      check_eq("re_poweroff", poweroff, 1);
      check_eq("re_tx_data", tx_data, 8'h80);
      check_eq("re_det", det_out, 0);
      check_eq("re_no_handshake", acc_cnt, 5);
      rst = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
